count_splitter: RTL and testbench
=================================

COUNT_SPLITTER -- requirements
Module: count_splitter

Interface
REQ-001 Parameter: DW, 15, dividend/quotient width; matches the 15-bit count result produced upstream.
REQ-002 Parameter: VW, 7, divisor/remainder width; matches the 7-bit A/B operand width upstream.
REQ-003 Port: clk_n  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  input  1  reset, synchronous and active-low.
REQ-005 Port: start  input  1  request pulse, sampled only in IDLE.
REQ-006 Port: dividend  input  DW  value to decompose (count = quotient*divisor + remainder).
REQ-007 Port: divisor  input  VW  unsigned divisor.
REQ-008 Port: busy  output  1  high in CALC.
REQ-009 Port: done  output  1  one-cycle pulse marking valid results.
REQ-010 Port: quotient  output  DW  unsigned quotient.
REQ-011 Port: remainder  output  VW  unsigned remainder, always < divisor when divisor != 0.
REQ-012 Port: div_zero  output  1  set with done when the captured divisor was 0.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE, with a 4-bit iteration counter.
REQ-014 In IDLE with start=1 and divisor!=0 at edge k, block SHALL latch dividend and divisor, clear the partial remainder, set counter to 0 and enter CALC.
REQ-015 In IDLE with start=1 and divisor==0 at edge k, block SHALL enter DONE directly with quotient=all ones, remainder=0 and div_zero=1.
REQ-016 CALC SHALL perform one restoring step per cycle, MSB first: shift the next dividend bit into the partial remainder (VW+1 bits wide); if partial >= divisor, subtract it and set the quotient bit to 1, else set it to 0.
REQ-017 CALC SHALL run exactly DW (15) steps, at edges k+1..k+15, then enter DONE; done SHALL be high in the cycle after edge k+15 (div_zero path: after edge k).
REQ-018 DONE SHALL last exactly one cycle and return to IDLE; done=1 only in DONE.
REQ-019 quotient, remainder and div_zero SHALL update only when entering DONE and SHALL hold until the next entry into DONE; intermediate values SHALL NOT be visible on them.
REQ-020 start SHALL be ignored in CALC and DONE, with no queuing; a start in the IDLE cycle right after DONE SHALL be accepted.
REQ-021 Changes on dividend/divisor after capture SHALL NOT affect the running operation.
REQ-022 div_zero SHALL clear to 0 on the next successful (divisor!=0) result.
REQ-023 Arithmetic is unsigned; no overflow is possible because quotient width equals dividend width.

Reset
REQ-024 With reset_n=0 at a rising edge, block SHALL enter IDLE and clear busy, done, quotient, remainder, div_zero and the counter to 0.
REQ-025 Reset during CALC or DONE SHALL abort the operation without producing a done pulse; reset SHALL take priority over start.
REQ-026 Operation SHALL resume normally on the first edge with reset_n=1; a start present at that edge is accepted.

Verification
REQ-027 dividend=2034, divisor=20, start at edge k -> busy at k+1..k+15, done after k+15, quotient=101, remainder=14, div_zero=0.
REQ-028 dividend=32767, divisor=1 -> quotient=32767, remainder=0; then dividend=0, divisor=127 -> quotient=0, remainder=0.
REQ-029 dividend=1234, divisor=0 -> done after edge k+1 cycle, quotient=32767, remainder=0, div_zero=1; next op (100/7) -> 14, 2, div_zero=0.
REQ-030 start with 2034/20, re-pulse start at k+5 with 99/9 and change the inputs -> single result 101/14, second start ignored.
REQ-031 reset_n=0 at k+8 of a 2034/20 operation -> no done, all outputs 0; a subsequent 2034/20 operation completes correctly.
REQ-032 Random sweep of 1000 operand pairs, start issued back-to-back in each first IDLE cycle -> quotient*divisor+remainder==dividend and remainder<divisor for every result.

Source files
------------

// File: rtl/count_splitter_if.sv
// Request/result bundle between a count source and the count_splitter divider.
// The master drives the operands and start; the slave returns status and results.
interface count_splitter_if #(
  parameter int unsigned DW = 15,
  parameter int unsigned VW = 7
) ();
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/count_splitter.sv
// Sequential restoring divider: splits a count into quotient*divisor + remainder,
// one quotient bit per cycle MSB first, results held until the next completion.
module count_splitter #(
  parameter int unsigned DW = 15,
  parameter int unsigned VW = 7
) (
  input  logic             clk_n,
  input  logic             reset_n,
  count_splitter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(DW - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;   // dividend bits shift out MSB, quotient bits shift in LSB
  logic [VW-1:0] dsr_q, dsr_d;
  logic [VW-1:0] part_q, part_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [VW:0]   trial;
  logic [DW-1:0] q_next;
  logic          qbit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    part_d  = part_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    trial   = '0;
    q_next  = dvd_q;
    qbit    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            dvd_d   = bus.dividend;
            dsr_d   = bus.divisor;
            part_d  = '0;
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        trial = {part_q, dvd_q[DW-1]};
        if (trial >= {1'b0, dsr_q}) begin
          qbit   = 1'b1;
          part_d = VW'(trial - {1'b0, dsr_q});
        end else begin
          part_d = trial[VW-1:0];
        end
        q_next = {dvd_q[DW-2:0], qbit};
        dvd_d  = q_next;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LastCnt) begin
          quot_d  = q_next;
          rem_d   = part_d;
          dz_d    = 1'b0;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      part_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      part_q  <= part_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = (state_q == StCalc);
  assign bus.done      = (state_q == StDone);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_count_splitter.sv
// Scoreboard bench for count_splitter: driver pushes model results, monitor pops on done
// and also checks that results hold steady between completions and clear on reset.
module tb_count_splitter;

  logic clk_n;
  logic reset_n;

  count_splitter_if bus ();

  count_splitter dut (
    .clk_n   (clk_n),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_n = 1'b0;
  always #5 clk_n = ~clk_n;

  typedef struct {
    logic [14:0] dvd;
    logic [6:0]  dsr;
    logic [14:0] q;
    logic [6:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [14:0] last_q;
  logic [6:0]  last_r;
  logic        last_dz;
  logic        rst_at_edge = 1'b0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer division; zero divisor saturates the quotient.
  task automatic push_exp(input logic [14:0] a, input logic [6:0] b);
    exp_t e;
    e.dvd = a;
    e.dsr = b;
    if (b == 0) begin
      e.q  = 15'h7fff;
      e.r  = 7'd0;
      e.dz = 1'b1;
    end else begin
      e.q  = 15'(int'(a) / int'(b));
      e.r  = 7'(int'(a) % int'(b));
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  always @(posedge clk_n) rst_at_edge <= !reset_n;

  // Monitor
  always @(negedge clk_n) begin
    if (rst_at_edge) begin
      mon_en = 1'b1;
      sb.delete();
      last_q  = '0;
      last_r  = '0;
      last_dz = 1'b0;
      chk("reset_quotient", 32'(bus.quotient), 32'd0);
      chk("reset_remainder", 32'(bus.remainder), 32'd0);
      chk("reset_div_zero", 32'(bus.div_zero), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
    end else if (mon_en) begin
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 32'(bus.quotient), 32'(e.q));
          chk("remainder", 32'(bus.remainder), 32'(e.r));
          chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
          if (e.dsr != 0) begin
            chk("recompose", 32'(bus.quotient) * 32'(e.dsr) + 32'(bus.remainder), 32'(e.dvd));
            chk("rem_lt_div", 32'(bus.remainder < e.dsr), 32'd1);
          end
          last_q  = e.q;
          last_r  = e.r;
          last_dz = e.dz;
        end
      end else begin
        chk("hold_quotient", 32'(bus.quotient), 32'(last_q));
        chk("hold_remainder", 32'(bus.remainder), 32'(last_r));
        chk("hold_div_zero", 32'(bus.div_zero), 32'(last_dz));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic do_op(input logic [14:0] a, input logic [6:0] b, input int repulse,
                       input int rst_at);
    int  lat;
    bit  seen;
    lat = (b == 0) ? 1 : 16;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk_n);
    push_exp(a, b);
    seen = 1'b0;
    for (int i = 1; i <= lat + 3 && !seen; i++) begin
      @(negedge clk_n);
      if (reset_n && bus.done === 1'b1) begin
        seen = 1'b1;
        chk("latency", 32'(i), 32'(lat));
        chk("busy_in_done", 32'(bus.busy), 32'd0);
      end else if (reset_n && rst_at == 0) begin
        chk("busy", 32'(bus.busy), 32'(b != 0));
      end
      // Scramble the operand lines to prove the captured copies are used.
      bus.start    = (i == repulse);
      bus.dividend = (i == repulse) ? 15'd99 : 15'($urandom);
      bus.divisor  = (i == repulse) ? 7'd9 : 7'($urandom);
      if (rst_at != 0 && i == rst_at) reset_n = 1'b0;
      if (rst_at != 0 && i == rst_at + 2) reset_n = 1'b1;
    end
    if (rst_at == 0 && !seen) chk("done_timeout", 32'd0, 32'd1);
    bus.start = 1'b0;
    if (rst_at == 0) @(negedge clk_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk_n);
    reset_n = 1'b1;
    @(negedge clk_n);

    do_op(15'd2034, 7'd20, 0, 0);
    do_op(15'd32767, 7'd1, 0, 0);
    do_op(15'd0, 7'd127, 0, 0);
    do_op(15'd1234, 7'd0, 0, 0);
    do_op(15'd100, 7'd7, 0, 0);
    do_op(15'd2034, 7'd20, 4, 0);

    // Reset lands at edge k+8; the pending result must never appear.
    do_op(15'd2034, 7'd20, 0, 7);
    repeat (20) @(negedge clk_n);
    reset_n = 1'b0;
    @(negedge clk_n);
    reset_n = 1'b1;
    do_op(15'd2034, 7'd20, 0, 0);

    for (int n = 0; n < 1000; n++) begin
      do_op(15'($urandom), 7'($urandom_range(0, 127)), 0, 0);
    end

    repeat (4) @(negedge clk_n);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
